// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS-15 (x^15 + x^14 + 1) error checker
// clk, reset (async, active-low), en qualifies data_in, clear zeroes both counters.
// locked: synchronised; err_pulse: one strobe per errored bit while locked;
// err_count / bit_count: saturating errored / total bits accepted while locked.
module prbs_checker #(
  parameter int LOCK_CNT  = 32,
  parameter int LOSS_WIN  = 64,
  parameter int LOSS_ERRS = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             data_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t state, state_n;
  logic [15:1] h;
  logic [3:0] fill;
  logic [7:0] match_cnt, win_cnt, win_err, werr_n;
  logic p, mis, hunt_acc, lock_acc, cnt_match, lock_hit, lose, win_end;
  always_comb begin
    p = h[14] ^ h[15];
    mis = data_in ^ p;
    hunt_acc = en && state == HUNT;
    lock_acc = en && state == LOCKED;
    // an all-zero history trivially predicts itself, so it must not build lock
    cnt_match = fill == 4'd15 && !mis && |h;
    lock_hit = hunt_acc && cnt_match && match_cnt == 8'(LOCK_CNT - 1);
    // the error on the closing bit of a window still counts toward loss
    werr_n = win_err + {7'd0, mis};
    lose = lock_acc && mis && werr_n == 8'(LOSS_ERRS);
    win_end = lose || win_cnt == 8'(LOSS_WIN - 1);
    state_n = lock_hit ? LOCKED : lose ? HUNT : state;
    locked = state == LOCKED;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= HUNT;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      h <= '0;
      fill <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      err_pulse <= lock_acc && mis;
      if (hunt_acc) begin
        h <= {h[14:1], data_in};
        fill <= fill == 4'd15 ? fill : fill + 4'd1;
        if (fill == 4'd15) match_cnt <= cnt_match && !lock_hit ? match_cnt + 8'd1 : 8'd0;
      end
      // once locked the LFSR free-runs so line errors never corrupt the reference
      if (lock_acc) begin
        h <= {h[14:1], p};
        win_cnt <= win_end ? 8'd0 : win_cnt + 8'd1;
        win_err <= win_end ? 8'd0 : werr_n;
        if (lose) begin
          fill <= '0;
          match_cnt <= '0;
        end
      end
      if (clear) begin
        err_count <= '0;
        bit_count <= '0;
      end else if (lock_acc) begin
        bit_count <= &bit_count ? bit_count : bit_count + CNT_W'(1);
        if (mis) err_count <= &err_count ? err_count : err_count + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: scoreboard bench for prbs_checker against a queue-based reference model
module tb_prbs_checker;
  localparam int LC = 32, LW = 64, LE = 8;
  logic clk = 1'b1, reset = 1'b1, en = 1'b0, data_in = 1'b0, clear = 1'b0;
  logic locked_a, pulse_a, locked_b, pulse_b;
  logic [31:0] ec_a, bc_a;
  logic [3:0] ec_b, bc_b;
  prbs_checker #(.LOCK_CNT(LC), .LOSS_WIN(LW), .LOSS_ERRS(LE), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clear(clear),
    .locked(locked_a), .err_pulse(pulse_a), .err_count(ec_a), .bit_count(bc_a));
  prbs_checker #(.LOCK_CNT(LC), .LOSS_WIN(LW), .LOSS_ERRS(LE), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in), .clear(clear),
    .locked(locked_b), .err_pulse(pulse_b), .err_count(ec_b), .bit_count(bc_b));
  always #5 clk = ~clk;
  typedef struct {
    logic lk, pl;
    logic [31:0] ec, bc;
    logic [3:0] ec4, bc4;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0, fails = 0;
  bit gq[$], mq[$];
  bit mlock;
  int mfill, mrun, wbits, werrs, mbc4, mec4;
  longint mbc, mec;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic bit gen();
    bit b = gq[0] ^ gq[1];
    gq.push_back(b);
    void'(gq.pop_front());
    return b;
  endfunction
  function automatic void model_reset();
    mq = {};
    repeat (15) mq.push_back(1'b0);
    mlock = 0; mfill = 0; mrun = 0; wbits = 0; werrs = 0;
    mbc = 0; mec = 0; mbc4 = 0; mec4 = 0;
  endfunction
  function automatic exp_t snap(bit pl);
    exp_t x;
    x.lk = mlock; x.pl = pl;
    x.ec = 32'(mec); x.bc = 32'(mbc);
    x.ec4 = 4'(mec4); x.bc4 = 4'(mbc4);
    return x;
  endfunction
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if ({locked_a, pulse_a, ec_a, bc_a} !== {mon_e.lk, mon_e.pl, mon_e.ec, mon_e.bc}) begin
        fails++;
        $display("FAIL sb_a: got lk=%b pl=%b ec=%0d bc=%0d expected lk=%b pl=%b ec=%0d bc=%0d",
                 locked_a, pulse_a, ec_a, bc_a, mon_e.lk, mon_e.pl, mon_e.ec, mon_e.bc);
      end
      checks++;
      if ({locked_b, pulse_b, ec_b, bc_b} !== {mon_e.lk, mon_e.pl, mon_e.ec4, mon_e.bc4}) begin
        fails++;
        $display("FAIL sb_b: got lk=%b pl=%b ec=%0d bc=%0d expected lk=%b pl=%b ec=%0d bc=%0d",
                 locked_b, pulse_b, ec_b, bc_b, mon_e.lk, mon_e.pl, mon_e.ec4, mon_e.bc4);
      end
    end
  end
  task automatic step(input bit e, input bit flip, input bit clr, input bit zero = 1'b0);
    bit d, p, err, allz, was;
    @(negedge clk);
    reset = 1'b1;
    en = e;
    clear = clr;
    d = zero ? 1'b0 : e ? gen() ^ flip : 1'($urandom);
    data_in = d;
    err = 0;
    was = mlock;
    if (e) begin
      p = mq[0] ^ mq[1];
      if (!mlock) begin
        allz = 1;
        foreach (mq[i]) if (mq[i]) allz = 0;
        mq.push_back(d);
        void'(mq.pop_front());
        if (mfill < 15) mfill++;
        else if (d == p && !allz) begin
          mrun++;
          if (mrun == LC) begin
            mlock = 1;
            mrun = 0;
          end
        end else mrun = 0;
      end else begin
        mq.push_back(p);
        void'(mq.pop_front());
        err = d != p;
        wbits++;
        werrs += int'(err);
        if (werrs == LE) begin
          mlock = 0; mfill = 0; mrun = 0; wbits = 0; werrs = 0;
        end else if (wbits == LW) begin
          wbits = 0; werrs = 0;
        end
      end
    end
    if (clr) begin
      mbc = 0; mec = 0; mbc4 = 0; mec4 = 0;
    end else if (e && was) begin
      if (mbc < 64'hFFFF_FFFF) mbc++;
      if (mbc4 < 15) mbc4++;
      if (err && mec < 64'hFFFF_FFFF) mec++;
      if (err && mec4 < 15) mec4++;
    end
    sb.push_back(snap(err));
    @(posedge clk);
    #1;
  endtask
  task automatic rst_step();
    @(negedge clk);
    reset = 1'b0;
    en = 1'($urandom);
    data_in = 1'($urandom);
    clear = 1'b0;
    #1;
    chk("rst_async_a", {locked_a, pulse_a, ec_a, bc_a}, 0);
    chk("rst_async_b", {locked_b, pulse_b, ec_b, bc_b}, 0);
    model_reset();
    sb.push_back(snap(1'b0));
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (14) gq.push_back(1'b0);
    gq.push_back(1'b1);
    model_reset();
    rst_step();
    rst_step();
    repeat (46) step(1, 0, 0);
    chk("pre_lock", locked_a, 0);
    step(1, 0, 0);
    chk("lock_at_47", locked_a, 1);
    repeat (1000) step(1, 0, 0);
    chk("clean_bc", bc_a, 1000);
    chk("clean_ec", ec_a, 0);
    step(1, 1, 0);
    chk("single_pulse", pulse_a, 1);
    step(1, 0, 0);
    chk("single_pulse_end", pulse_a, 0);
    repeat (100) step(1, 0, 0);
    chk("single_ec", ec_a, 1);
    chk("single_locked", locked_a, 1);
    while (wbits != 0) step(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 0);
      if (i < 7) repeat (3) step(1, 0, 0);
    end
    chk("loss_locked", locked_a, 0);
    chk("loss_ec", ec_a, 9);
    repeat (46) step(1, 0, 0);
    chk("relock_pre", locked_a, 0);
    step(1, 0, 0);
    chk("relock_47", locked_a, 1);
    while (wbits != 0) step(1, 0, 0);
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 64; i++) step(1, w == 0 ? i >= 57 : i < 7, 0);
    chk("win_locked", locked_a, 1);
    chk("win_ec", ec_a, 23);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0);
      repeat (9) step(1, 0, 0);
    end
    chk("sat_ec4", ec_b, 15);
    chk("sat_bc4", bc_b, 15);
    chk("sat_ec32", ec_a, 43);
    step(1, 1, 1);
    chk("clear_ec", ec_a, 0);
    chk("clear_bc", bc_a, 0);
    chk("clear_pulse", pulse_a, 1);
    rst_step();
    chk("rst_locked", locked_a, 0);
    repeat (500) step(1, 0, 0, 1);
    chk("zero_nolock", locked_a, 0);
    for (int i = 0; i < 200; i++) step(i % 2 == 0, 0, 0);
    chk("gap_lock", locked_a, 1);
    repeat (3000) step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 99) == 0);
    repeat (1500) step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
